// File: rtl/stopwatch_pkg.sv
// Stopwatch shared definitions.
// Holds the control FSM state type, BCD digit sizing constants, the cleared
// time value and a helper that gives each digit position its rollover limit.
package stopwatch_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2,
        StLap  = 2'd3
    } state_e;

    // Width of one BCD digit.
    localparam int unsigned DigitW = 4;

    // Number of digits in MM:SS.cc.
    localparam int unsigned NumDigits = 6;

    // Rollover limit of the decimal (units) digits.
    localparam int unsigned DigitMaxUnits = 9;

    // Cleared time value 00:00.00.
    localparam logic [NumDigits*DigitW-1:0] TimeReset = 24'h000000;

    // Digit index 0 is cs_units, 5 is m_tens. Seconds-tens (3) and
    // minutes-tens (5) roll over at the tens limit, everything else at 9.
    function automatic int unsigned digit_max(input int unsigned idx,
                                              input int unsigned tens_limit);
        if (idx == 3 || idx == 5) begin
            return tens_limit;
        end
        return DigitMaxUnits;
    endfunction

endpackage

// File: rtl/stopwatch_time_keeper_bcd_digit.sv
// One BCD counter digit.
// Advances by one on inc, returning to 0 after MAX. clr forces 0 and takes
// priority over inc; synchronous active-low reset forces 0.
//   CLK    : system clock
//   rst_n  : synchronous active-low reset
//   clr    : synchronous clear to 0
//   inc    : advance this digit (already qualified by lower-digit carries)
//   q      : current digit value
//   at_max : digit currently holds MAX (carry into the next digit)
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = DigitMaxUnits
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [DigitW-1:0] q,
    output logic              at_max
);

    logic [DigitW-1:0] q_q;
    logic [DigitW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = at_max ? '0 : q_q + DigitW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign at_max = (q_q == DigitW'(MAX));
    assign q      = q_q;

endmodule

// File: rtl/stopwatch_time_keeper.sv
// Stopwatch time keeper.
// Accumulates elapsed time as BCD MM:SS.cc from a 100 Hz tick, runs the
// start/stop/lap/clear control FSM and holds the lap-freeze display copy.
//   CLK        : system clock
//   rst_n      : synchronous active-low reset
//   tick       : 100 Hz enable, one CLK cycle wide
//   btn_start  : start/stop button (level or pulse, see EDGE_DETECT)
//   btn_lap    : lap/clear button (level or pulse, see EDGE_DETECT)
//   digits     : {m_tens, m_units, s_tens, s_units, cs_tens, cs_units}
//   running    : high in RUN and LAP
//   lap_active : high in LAP, display frozen on the lap copy
//   wrapped    : sticky, set when time rolls over from the maximum value
module stopwatch_time_keeper
    import stopwatch_pkg::*;
#(
    parameter int unsigned TENS_LIMIT  = 5,
    parameter bit          EDGE_DETECT = 1'b1
) (
    input  logic                        CLK,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        btn_start,
    input  logic                        btn_lap,
    output logic [NumDigits*DigitW-1:0] digits,
    output logic                        running,
    output logic                        lap_active,
    output logic                        wrapped
);

    localparam int unsigned TimeW = NumDigits * DigitW;

    // ------------------------------------------------------------------
    // Button press detection
    // ------------------------------------------------------------------
    logic start_press;
    logic lap_press;

    if (EDGE_DETECT) begin : g_edge
        logic btn_start_q;
        logic btn_start_d;
        logic btn_lap_q;
        logic btn_lap_d;

        always_comb begin
            btn_start_d = btn_start;
            btn_lap_d   = btn_lap;
        end

        // History resets to 1 so a button held through reset is not a press.
        always_ff @(posedge CLK) begin
            if (!rst_n) begin
                btn_start_q <= 1'b1;
                btn_lap_q   <= 1'b1;
            end else begin
                btn_start_q <= btn_start_d;
                btn_lap_q   <= btn_lap_d;
            end
        end

        assign start_press = btn_start & ~btn_start_q;
        assign lap_press   = btn_lap & ~btn_lap_q;
    end else begin : g_pulse
        assign start_press = btn_start;
        assign lap_press   = btn_lap;
    end

    // Start wins over a simultaneous lap press.
    logic lap_only;
    assign lap_only = lap_press & ~start_press;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;
    logic   lap_load;   // copy live time into the lap registers
    logic   clear_all;  // STOP -> IDLE: clear live time, lap copy, wrapped

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lap_load  = 1'b0;
        clear_all = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_press) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (start_press) begin
                    state_d = StStop;
                end else if (lap_only) begin
                    state_d  = StLap;
                    lap_load = 1'b1;
                end
            end
            StLap: begin
                if (start_press) begin
                    state_d = StStop;
                end else if (lap_only) begin
                    state_d = StRun;
                end
            end
            StStop: begin
                if (start_press) begin
                    state_d = StRun;
                end else if (lap_only) begin
                    state_d   = StIdle;
                    clear_all = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        running    = (state_q == StRun) || (state_q == StLap);
        lap_active = (state_q == StLap);
    end

    // ------------------------------------------------------------------
    // Live time counter
    // ------------------------------------------------------------------
    // Counting follows the pre-transition state, so a tick on IDLE->RUN or
    // STOP->RUN is dropped while one on RUN->STOP or RUN->LAP is kept.
    logic                    count_en;
    logic [NumDigits-1:0]    dig_inc;
    logic [NumDigits-1:0]    dig_at_max;
    logic [TimeW-1:0]        live_time;

    assign count_en = tick & running;

    // Ripple carry: a digit advances only when all lower digits are at max.
    always_comb begin
        dig_inc[0] = count_en;
        for (int i = 1; i < NumDigits; i++) begin
            dig_inc[i] = dig_inc[i-1] & dig_at_max[i-1];
        end
    end

    for (genvar g = 0; g < NumDigits; g++) begin : g_digit
        bcd_digit #(
            .MAX (digit_max(g, TENS_LIMIT))
        ) u_digit (
            .CLK    (CLK),
            .rst_n  (rst_n),
            .clr    (clear_all),
            .inc    (dig_inc[g]),
            .q      (live_time[g*DigitW +: DigitW]),
            .at_max (dig_at_max[g])
        );
    end

    // ------------------------------------------------------------------
    // Lap copy and wrap flag
    // ------------------------------------------------------------------
    logic [TimeW-1:0] lap_time_q;
    logic [TimeW-1:0] lap_time_d;
    logic             wrapped_q;
    logic             wrapped_d;
    logic             wrap_now;

    // Carry out of the top digit means the whole time rolled over.
    assign wrap_now = dig_inc[NumDigits-1] & dig_at_max[NumDigits-1];

    always_comb begin
        lap_time_d = lap_time_q;
        wrapped_d  = wrapped_q;
        if (clear_all) begin
            lap_time_d = TimeReset;
            wrapped_d  = 1'b0;
        end else begin
            // Registered live_time is the pre-increment value on a lap tick.
            if (lap_load) begin
                lap_time_d = live_time;
            end
            if (wrap_now) begin
                wrapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            lap_time_q <= TimeReset;
            wrapped_q  <= 1'b0;
        end else begin
            lap_time_q <= lap_time_d;
            wrapped_q  <= wrapped_d;
        end
    end

    always_comb begin
        digits  = lap_active ? lap_time_q : live_time;
        wrapped = wrapped_q;
    end

endmodule

// File: tb/tb_stopwatch_time_keeper.sv
// Directed bench for stopwatch_time_keeper. dut_a uses the default digit
// limits; dut_b uses TENS_LIMIT=0 so the full-scale rollover (09:09.99)
// is reachable in a few thousand cycles.
module tb_stopwatch_time_keeper;

    logic        CLK = 1'b0;
    logic        rst_n_a, tick_a, start_a, lap_a;
    logic        rst_n_b, tick_b, start_b, lap_b;
    logic [23:0] digits_a, digits_b;
    logic        running_a, lap_active_a, wrapped_a;
    logic        running_b, lap_active_b, wrapped_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    stopwatch_time_keeper #(
        .TENS_LIMIT  (5),
        .EDGE_DETECT (1'b1)
    ) dut_a (
        .CLK        (CLK),
        .rst_n      (rst_n_a),
        .tick       (tick_a),
        .btn_start  (start_a),
        .btn_lap    (lap_a),
        .digits     (digits_a),
        .running    (running_a),
        .lap_active (lap_active_a),
        .wrapped    (wrapped_a)
    );

    stopwatch_time_keeper #(
        .TENS_LIMIT  (0),
        .EDGE_DETECT (1'b1)
    ) dut_b (
        .CLK        (CLK),
        .rst_n      (rst_n_b),
        .tick       (tick_b),
        .btn_start  (start_b),
        .btn_lap    (lap_b),
        .digits     (digits_b),
        .running    (running_b),
        .lap_active (lap_active_b),
        .wrapped    (wrapped_b)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press_a(input logic s, input logic l);
        start_a = s;
        lap_a   = l;
        cyc();
        start_a = 1'b0;
        lap_a   = 1'b0;
        cyc();
    endtask

    task automatic ticks_a(input int n);
        tick_a = 1'b1;
        repeat (n) cyc();
        tick_a = 1'b0;
    endtask

    task automatic press_b(input logic s, input logic l);
        start_b = s;
        lap_b   = l;
        cyc();
        start_b = 1'b0;
        lap_b   = 1'b0;
        cyc();
    endtask

    task automatic ticks_b(input int n);
        tick_b = 1'b1;
        repeat (n) cyc();
        tick_b = 1'b0;
    endtask

    initial begin
        rst_n_a = 1'b0; tick_a = 1'b0; start_a = 1'b1; lap_a = 1'b0;
        rst_n_b = 1'b0; tick_b = 1'b0; start_b = 1'b0; lap_b = 1'b0;
        cyc();
        cyc();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        cyc();

        // 1: reset state, start held through reset must not start.
        check("rst_digits", digits_a, 24'h000000);
        check("rst_running", {23'd0, running_a}, 24'd0);
        check("rst_wrapped", {23'd0, wrapped_a}, 24'd0);
        ticks_a(5);
        check("held_digits", digits_a, 24'h000000);
        check("held_running", {23'd0, running_a}, 24'd0);
        start_a = 1'b0;
        cyc();

        // 2: start, 123 ticks, stop; further ticks ignored.
        press_a(1'b1, 1'b0);
        check("start_running", {23'd0, running_a}, 24'd1);
        ticks_a(123);
        press_a(1'b1, 1'b0);
        check("stop_digits", digits_a, 24'h000123);
        check("stop_running", {23'd0, running_a}, 24'd0);
        ticks_a(10);
        check("stopped_ticks", digits_a, 24'h000123);

        // 3: resume to 12.34, lap freeze, lap release.
        press_a(1'b1, 1'b0);
        ticks_a(1111);
        check("run_1234", digits_a, 24'h001234);
        press_a(1'b0, 1'b1);
        check("lap_on", {23'd0, lap_active_a}, 24'd1);
        ticks_a(50);
        check("lap_frozen", digits_a, 24'h001234);
        press_a(1'b0, 1'b1);
        check("lap_release", digits_a, 24'h001284);
        check("lap_off", {23'd0, lap_active_a}, 24'd0);
        check("lap_off_run", {23'd0, running_a}, 24'd1);

        // Tick on the RUN->LAP cycle: counted, but the copy is pre-increment.
        tick_a = 1'b1;
        lap_a  = 1'b1;
        cyc();
        tick_a = 1'b0;
        lap_a  = 1'b0;
        cyc();
        check("lap_tick_copy", digits_a, 24'h001284);
        press_a(1'b0, 1'b1);
        check("lap_tick_live", digits_a, 24'h001285);

        // Stop and clear, then seconds-tens to minutes carry.
        press_a(1'b1, 1'b0);
        press_a(1'b0, 1'b1);
        check("clear_digits", digits_a, 24'h000000);
        check("clear_running", {23'd0, running_a}, 24'd0);
        press_a(1'b1, 1'b0);
        ticks_a(5999);
        check("run_5999", digits_a, 24'h005999);
        ticks_a(1);
        check("min_carry", digits_a, 24'h010000);

        // Tick on RUN->STOP is counted.
        tick_a  = 1'b1;
        start_a = 1'b1;
        cyc();
        tick_a  = 1'b0;
        start_a = 1'b0;
        cyc();
        check("stop_tick", digits_a, 24'h010001);
        check("stop_tick_run", {23'd0, running_a}, 24'd0);
        press_a(1'b0, 1'b1);
        check("clear2", digits_a, 24'h000000);

        // 5: tick on IDLE->RUN is dropped; start+lap from RUN -> STOP.
        tick_a  = 1'b1;
        start_a = 1'b1;
        cyc();
        tick_a  = 1'b0;
        start_a = 1'b0;
        cyc();
        check("start_tick", digits_a, 24'h000000);
        check("start_tick_run", {23'd0, running_a}, 24'd1);
        ticks_a(3);
        press_a(1'b1, 1'b1);
        check("both_running", {23'd0, running_a}, 24'd0);
        check("both_lap", {23'd0, lap_active_a}, 24'd0);
        check("both_digits", digits_a, 24'h000003);
        // In STOP a lap press clears; proves the state really is STOP.
        press_a(1'b0, 1'b1);
        check("both_clear", digits_a, 24'h000000);

        // 6: reset in LAP at 00:45.67.
        press_a(1'b1, 1'b0);
        ticks_a(4567);
        press_a(1'b0, 1'b1);
        check("lap_4567", digits_a, 24'h004567);
        ticks_a(10);
        rst_n_a = 1'b0;
        cyc();
        rst_n_a = 1'b1;
        check("mid_rst_digits", digits_a, 24'h000000);
        check("mid_rst_running", {23'd0, running_a}, 24'd0);
        check("mid_rst_lap", {23'd0, lap_active_a}, 24'd0);
        check("mid_rst_wrapped", {23'd0, wrapped_a}, 24'd0);

        // 4: full-scale wrap on dut_b (max 09:09.99 with TENS_LIMIT=0).
        press_b(1'b1, 1'b0);
        ticks_b(9998);
        check("b_pre_wrap", digits_b, 24'h090998);
        ticks_b(1);
        check("b_max", digits_b, 24'h090999);
        check("b_not_wrapped", {23'd0, wrapped_b}, 24'd0);
        ticks_b(1);
        check("b_wrap_digits", digits_b, 24'h000000);
        check("b_wrap_flag", {23'd0, wrapped_b}, 24'd1);
        ticks_b(1);
        check("b_wrap_cont", digits_b, 24'h000001);
        press_b(1'b1, 1'b0);
        check("b_stop_wrapped", {23'd0, wrapped_b}, 24'd1);
        press_b(1'b0, 1'b1);
        check("b_clear_wrapped", {23'd0, wrapped_b}, 24'd0);
        check("b_clear_digits", digits_b, 24'h000000);

        // Wrapped is also cleared by reset while running.
        press_b(1'b1, 1'b0);
        ticks_b(10000);
        check("b_wrap2_flag", {23'd0, wrapped_b}, 24'd1);
        rst_n_b = 1'b0;
        cyc();
        rst_n_b = 1'b1;
        check("b_rst_wrapped", {23'd0, wrapped_b}, 24'd0);
        check("b_rst_running", {23'd0, running_b}, 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_time_keeper.md
Name: stopwatch_time_keeper

Overview:
- Consumes the 100 Hz enable pulse from the 18-bit prescaler (250000 clocks per pulse at 25 MHz) and accumulates elapsed time as BCD digits MM:SS.cc.
- Contains the start/stop/lap/clear control FSM and lap-freeze display registers.
- Sits between the prescaler and the 7-segment display multiplexer in the stopwatch top level.

Parameters:
- TENS_LIMIT, 5, maximum value of the seconds-tens and minutes-tens digits (rollover after TENS_LIMIT).
- EDGE_DETECT, 1, 1 = btn_* are debounced levels and the block detects rising edges internally; 0 = btn_* are already single-cycle pulses.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the CLK rising edge.
- tick  in  1  100 Hz enable pulse, high for exactly one CLK cycle.
- btn_start  in  1  start/stop button.
- btn_lap  in  1  lap/clear button.
- digits  out  24  display time {m_tens, m_units, s_tens, s_units, cs_tens, cs_units}, 4-bit BCD each, cs_units in [3:0].
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP (display frozen).
- wrapped  out  1  sticky; set on rollover from 59:59.99.

Behaviour:
- Reset (rst_n=0 at a CLK edge): state=IDLE, live and lap registers 00:00.00, wrapped=0, edge-detect history registers=1. A button held through reset does not generate an edge. Reset overrides all other events, including in the middle of a count or while in LAP.
- Edge detect (EDGE_DETECT=1): press = btn & ~btn_q, where btn_q is the previous-cycle sample. FSM reacts on the same edge at which the press is first sampled, so outputs change 1 cycle after the input rises.
- States: IDLE, RUN, STOP, LAP.
  - IDLE: start -> RUN; lap ignored.
  - RUN: start -> STOP; lap -> LAP and copy live time into the lap registers.
  - LAP: start -> STOP (display returns to live time); lap -> RUN (display live).
  - STOP: start -> RUN (resume); lap -> IDLE, clearing live time, lap registers and wrapped.
- Simultaneous start and lap presses in the same cycle: start wins, lap is discarded.
- Counting:
  - The live time increments by 1 cs on every cycle with tick=1 while the current (pre-transition) state is RUN or LAP.
  - A tick coinciding with IDLE->RUN or STOP->RUN is not counted.
  - A tick coinciding with RUN->STOP is counted.
  - A tick coinciding with RUN->LAP is counted, but the lap copy takes the pre-increment value.
- Digit arithmetic:
  - cs_units, cs_tens, s_units, m_units count 0..9.
  - s_tens and m_tens count 0..TENS_LIMIT.
  - Each digit advances only when all lower digits are at their maximum; a digit at its maximum that advances returns to 0.
- Wrap: 59:59.99 + tick -> 00:00.00, wrapped=1, and counting continues. wrapped clears only on the STOP->IDLE clear or on reset.
- digits = lap registers in LAP, live registers otherwise. This is a pure mux of registered values; no added latency.
- Invalid BCD values are unreachable; no recovery logic is required.

Decomposition:
- Package stopwatch_pkg:
  - state enum (IDLE, RUN, STOP, LAP, 2-bit);
  - digit width 4;
  - DIGIT_MAX_UNITS=9;
  - reset time constant 24'h000000.
- Sub-module bcd_digit:
  - parameter MAX;
  - inputs CLK, rst_n, clr, inc;
  - outputs q[3:0], at_max;
  - instantiated six times, with inc chained through the AND of lower at_max flags.
- The FSM and lap registers stay in stopwatch_time_keeper.

Test Plan:
1. Reset with btn_start held high, then 5 ticks -> state IDLE, digits=24'h000000, running=0; holding the button through reset never starts the stopwatch.
2. Press start, 123 ticks, press start -> digits=24'h000123, running=0; a further 10 ticks leave digits unchanged.
3. Run to 00:12.34, press lap, 50 more ticks -> digits stay 24'h001234 with lap_active=1. Press lap again -> digits=24'h001284.
4. Preload by ticking to 59:59.98 (359998 ticks), then 2 ticks -> 59:59.99, then 00:00.00 with wrapped=1. Stop then lap-clear -> wrapped=0, digits=0.
5. start and lap pressed in the same cycle from RUN -> STOP, lap discarded, lap_active=0. Tick on the same cycle as the start press from IDLE -> digits remain 24'h000000.
6. Assert rst_n=0 for one cycle mid-RUN at 00:45.67 (LAP active) -> next cycle: digits=0, running=0, lap_active=0, wrapped=0.
